// File: rtl/uart_receiver.sv
// Receive end of the 7-bit UART link: 1 start, 7 data (LSB first), even parity, 1 stop.
// Bits are sampled at mid-bit; each frame is presented as a one-cycle rx_valid pulse with error flags.
module uart_receiver #(
   parameter int unsigned CLK_PERIOD = 50,
   parameter int unsigned BIT_TIME   = 104167
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_serial_bit,
   output logic [6:0] rx_data,
   output logic       rx_valid,
   output logic       parity_err,
   output logic       frame_err,
   output logic       busy
);

   localparam int unsigned CLKS_PER_BIT = BIT_TIME / CLK_PERIOD;
   localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] START     = 3'd1;
   localparam logic [2:0] DATA      = 3'd2;
   localparam logic [2:0] PARITY    = 3'd3;
   localparam logic [2:0] STOP      = 3'd4;
   localparam logic [2:0] WAIT_HIGH = 3'd5;

   logic             sync1_q;
   logic             rxS_q;
   logic [2:0]       state_q,     state_d;
   logic [CNT_W-1:0] clkCnt_q,    clkCnt_d;
   logic [2:0]       bitIdx_q,    bitIdx_d;
   logic [6:0]       shift_q,     shift_d;
   logic             parBit_q,    parBit_d;
   logic [6:0]       rxData_q,    rxData_d;
   logic             rxValid_q,   rxValid_d;
   logic             parityErr_q, parityErr_d;
   logic             frameErr_q,  frameErr_d;
   logic             busy_q,      busy_d;

   always_comb begin
      state_d     = state_q;
      clkCnt_d    = clkCnt_q;
      bitIdx_d    = bitIdx_q;
      shift_d     = shift_q;
      parBit_d    = parBit_q;
      rxData_d    = rxData_q;
      rxValid_d   = 1'b0;
      parityErr_d = parityErr_q;
      frameErr_d  = frameErr_q;

      case (state_q)
         IDLE: begin
            if (!rxS_q) begin
               state_d  = START;
               clkCnt_d = '0;
            end
         end
         // A start bit must still be low at its midpoint, otherwise it was a glitch.
         START: begin
            if (clkCnt_q == HALF_LAST) begin
               clkCnt_d = '0;
               if (!rxS_q) begin
                  state_d  = DATA;
                  bitIdx_d = '0;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               clkCnt_d = clkCnt_q + 1'b1;
            end
         end
         DATA: begin
            if (clkCnt_q == BIT_LAST) begin
               clkCnt_d          = '0;
               shift_d[bitIdx_q] = rxS_q;
               if (bitIdx_q == 3'd6) begin
                  state_d = PARITY;
               end else begin
                  bitIdx_d = bitIdx_q + 3'd1;
               end
            end else begin
               clkCnt_d = clkCnt_q + 1'b1;
            end
         end
         PARITY: begin
            if (clkCnt_q == BIT_LAST) begin
               clkCnt_d = '0;
               parBit_d = rxS_q;
               state_d  = STOP;
            end else begin
               clkCnt_d = clkCnt_q + 1'b1;
            end
         end
         // Results are registered here so they appear together with rx_valid.
         STOP: begin
            if (clkCnt_q == BIT_LAST) begin
               clkCnt_d    = '0;
               rxValid_d   = 1'b1;
               rxData_d    = shift_q;
               parityErr_d = (^shift_q) ^ parBit_q;
               frameErr_d  = ~rxS_q;
               state_d     = rxS_q ? IDLE : WAIT_HIGH;
            end else begin
               clkCnt_d = clkCnt_q + 1'b1;
            end
         end
         WAIT_HIGH: begin
            if (rxS_q) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q     <= 1'b1;
         rxS_q       <= 1'b1;
         state_q     <= IDLE;
         clkCnt_q    <= '0;
         bitIdx_q    <= '0;
         shift_q     <= '0;
         parBit_q    <= 1'b0;
         rxData_q    <= '0;
         rxValid_q   <= 1'b0;
         parityErr_q <= 1'b0;
         frameErr_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         sync1_q     <= in_serial_bit;
         rxS_q       <= sync1_q;
         state_q     <= state_d;
         clkCnt_q    <= clkCnt_d;
         bitIdx_q    <= bitIdx_d;
         shift_q     <= shift_d;
         parBit_q    <= parBit_d;
         rxData_q    <= rxData_d;
         rxValid_q   <= rxValid_d;
         parityErr_q <= parityErr_d;
         frameErr_q  <= frameErr_d;
         busy_q      <= busy_d;
      end
   end

   assign rx_data    = rxData_q;
   assign rx_valid   = rxValid_q;
   assign parity_err = parityErr_q;
   assign frame_err  = frameErr_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed and random frames, scoreboard queue
// filled by the driver and drained by an independent rx_valid monitor.
module tb_uart_receiver;

   localparam int CLKS = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       serial = 1'b1;
   logic [6:0] rx_data;
   logic       rx_valid;
   logic       parity_err;
   logic       frame_err;
   logic       busy;

   typedef struct packed {
      logic [6:0] data;
      logic       perr;
      logic       ferr;
   } exp_t;

   exp_t expQ[$];
   int   validCycles[$];
   exp_t monExp;
   int   checks = 0;
   int   errors = 0;
   int   cycle = 0;
   int   startEdge = 0;

   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   uart_receiver #(.CLK_PERIOD(50), .BIT_TIME(800)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_serial_bit(serial),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .parity_err   (parity_err),
      .frame_err    (frame_err),
      .busy         (busy)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, actual, expected, cycle);
      end
   endtask

   // Monitor: every rx_valid pulse consumes the oldest expected frame.
   always @(negedge clk) begin
      if (rx_valid === 1'b1) begin
         validCycles.push_back(cycle);
         if (expQ.size() == 0) begin
            checkOutput("unexpected_rx_valid", 32'd1, 32'd0);
         end else begin
            monExp = expQ.pop_front();
            checkOutput("rx_data", 32'(rx_data), 32'(monExp.data));
            checkOutput("parity_err", 32'(parity_err), 32'(monExp.perr));
            checkOutput("frame_err", 32'(frame_err), 32'(monExp.ferr));
         end
      end
   end

   // Reference model: even parity means the ones among data+parity bit sum to an even count.
   task automatic applyStimulus(input logic [6:0] data, input bit flipPar, input bit stopBit);
      bit   parBit;
      exp_t e;
      parBit = bit'($countones(data) % 2) ^ flipPar;
      e.data = data;
      e.perr = ((($countones(data) + int'(parBit)) % 2) != 0);
      e.ferr = !stopBit;
      expQ.push_back(e);
      serial    = 1'b0;
      startEdge = cycle + 1;
      repeat (CLKS) @(negedge clk);
      for (int i = 0; i < 7; i++) begin
         serial = data[i];
         repeat (CLKS) @(negedge clk);
      end
      serial = parBit;
      repeat (CLKS) @(negedge clk);
      serial = stopBit;
      repeat (CLKS) @(negedge clk);
   endtask

   task automatic waitDrain();
      for (int i = 0; i < 300 && expQ.size() != 0; i++) @(negedge clk);
      checkOutput("frames_drained", 32'(expQ.size()), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cycle);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int lat;
      int gap;
      logic [6:0] d;
      bit fp;
      bit sb;

      rst_n  = 1'b0;
      serial = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("reset_rx_valid", 32'(rx_valid), 32'd0);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_rx_data", 32'(rx_data), 32'd0);
      checkOutput("reset_parity_err", 32'(parity_err), 32'd0);
      checkOutput("reset_frame_err", 32'(frame_err), 32'd0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      $display("[TB] test 1: clean frame 0x55");
      validCycles.delete();
      applyStimulus(7'h55, 1'b0, 1'b1);
      waitDrain();
      if (validCycles.size() == 0) begin
         checkOutput("latency_pulse_seen", 32'd0, 32'd1);
      end else begin
         lat = validCycles[0] - startEdge + 1;
         checkOutput("latency_in_range", 32'(lat >= 154 && lat <= 158), 32'd1);
      end
      repeat (4) @(negedge clk);
      checkOutput("t1_busy_idle", 32'(busy), 32'd0);

      $display("[TB] test 2: parity error on 0x7F");
      applyStimulus(7'h7F, 1'b1, 1'b1);
      waitDrain();
      repeat (4) @(negedge clk);

      $display("[TB] test 3: framing error then held-low line");
      applyStimulus(7'h12, 1'b0, 1'b0);
      repeat (40) @(negedge clk);
      waitDrain();
      checkOutput("t3_busy_while_low", 32'(busy), 32'd1);
      serial = 1'b1;
      repeat (5) @(negedge clk);
      checkOutput("t3_busy_after_high", 32'(busy), 32'd0);

      $display("[TB] test 4: start glitch");
      serial = 1'b0;
      repeat (4) @(negedge clk);
      checkOutput("t4_busy_during_glitch", 32'(busy), 32'd1);
      serial = 1'b1;
      repeat (20) @(negedge clk);
      checkOutput("t4_busy_after_glitch", 32'(busy), 32'd0);
      applyStimulus(7'h01, 1'b0, 1'b1);
      waitDrain();
      repeat (4) @(negedge clk);

      $display("[TB] test 5: back-to-back frames");
      validCycles.delete();
      applyStimulus(7'h3C, 1'b0, 1'b1);
      applyStimulus(7'h41, 1'b0, 1'b1);
      waitDrain();
      checkOutput("t5_pulse_count", 32'(validCycles.size()), 32'd2);
      if (validCycles.size() == 2) begin
         gap = validCycles[1] - validCycles[0];
         checkOutput("t5_spacing_in_range", 32'(gap >= 158 && gap <= 162), 32'd1);
      end
      repeat (4) @(negedge clk);

      $display("[TB] test 6: reset during data");
      d = 7'h55;
      serial = 1'b0;
      repeat (CLKS) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         serial = d[i];
         repeat (CLKS) @(negedge clk);
      end
      rst_n = 1'b0;
      @(negedge clk);
      checkOutput("t6_rx_valid", 32'(rx_valid), 32'd0);
      checkOutput("t6_busy", 32'(busy), 32'd0);
      checkOutput("t6_rx_data", 32'(rx_data), 32'd0);
      checkOutput("t6_parity_err", 32'(parity_err), 32'd0);
      checkOutput("t6_frame_err", 32'(frame_err), 32'd0);
      serial = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      applyStimulus(7'h2A, 1'b0, 1'b1);
      waitDrain();
      repeat (4) @(negedge clk);

      $display("[TB] random frames");
      for (int n = 0; n < 12; n++) begin
         d  = 7'($urandom_range(0, 127));
         fp = ($urandom_range(0, 3) == 0);
         sb = ($urandom_range(0, 4) != 0);
         applyStimulus(d, fp, sb);
         if (!sb) begin
            repeat ($urandom_range(5, 30)) @(negedge clk);
            serial = 1'b1;
            repeat (4) @(negedge clk);
         end
         repeat ($urandom_range(0, 20)) @(negedge clk);
      end
      waitDrain();
      repeat (10) @(negedge clk);
      checkOutput("final_busy", 32'(busy), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
